match_req_sched: RTL and testbench

Per-job-PE scheduler that takes one lazy-match request group (up to L lanes, strobe-masked) and issues the lanes as tagged single requests over C match-PE request channels. Each tag is the lane index. It pulses the group-load strobe to `match_resp_sync` in the cycle the group is accepted. It blocks the next group until the matching response group has been consumed, so only one group per job PE is in flight.

---
 rtl/match_req_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_match_req_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_req_sched.sv
// match_req_sched
// ---------------
// Per-job-PE scheduler for lazy-match request groups. It accepts one group
// of up to L strobe-masked lanes and issues the set lanes as tagged single
// requests over C match-PE request channels. Each tag is the lane index.
// In the accept cycle it pulses sync_fire to match_resp_sync. It then blocks
// further groups until the matching response group has been consumed, so at
// most one group per job PE is in flight.
//
// Optional feature macro: MATCH_REQ_SCHED_RR_EN
//   When defined, the channel fill order starts at a rotating pointer.
//   The pointer advances every cycle in which any channel is loaded.
//   When undefined, the fill order is always channel 0 first, ascending.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_group_valid/ready, req_group_strb[L], req_group_addr[L*AW]
//                       group handshake, lane mask, lane payloads
//   match_req_valid/ready[C], match_req_tag[C*TAG_BITS], match_req_addr[C*AW]
//                       per-channel single-lane requests
//   sync_fire, sync_strb[L]
//                       group-load pulse and mask to the response sync
//   resp_group_fire     response group consumed (valid & ready at the sync)
//   busy                scheduler is not idle

`ifndef LAZY_LEN
`define LAZY_LEN 4
`endif
`ifndef NUM_MATCH_REQ_CH
`define NUM_MATCH_REQ_CH 2
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 2
`endif

module match_req_sched #(
  parameter int JOB_PE_IDX = 0,
  parameter int L          = `LAZY_LEN,
  parameter int C          = `NUM_MATCH_REQ_CH,
  parameter int TAG_BITS   = `LAZY_LEN_LOG2,
  parameter int AW         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_group_valid,
  output logic                  req_group_ready,
  input  logic [L-1:0]          req_group_strb,
  input  logic [L*AW-1:0]       req_group_addr,
  output logic [C-1:0]          match_req_valid,
  input  logic [C-1:0]          match_req_ready,
  output logic [C*TAG_BITS-1:0] match_req_tag,
  output logic [C*AW-1:0]       match_req_addr,
  output logic                  sync_fire,
  output logic [L-1:0]          sync_strb,
  input  logic                  resp_group_fire,
  output logic                  busy
);

  // JOB_PE_IDX only identifies the instance when debugging; a negative
  // index is meaningless, and nothing is built from it either way.
  if (JOB_PE_IDX < 0) begin : g_job_pe_idx_unused
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t              state_q, state_d;
  logic [C-1:0]        ch_valid_q, ch_valid_d;
  logic [TAG_BITS-1:0] ch_tag_q  [C];
  logic [TAG_BITS-1:0] ch_tag_d  [C];
  logic [AW-1:0]       ch_addr_q [C];
  logic [AW-1:0]       ch_addr_d [C];
  logic [L-1:0]        pending_q, pending_d;
  logic [L*AW-1:0]     payload_q, payload_d;
  logic                resp_seen_q, resp_seen_d;

  logic                accept;
  logic [L-1:0]        avail;
  logic [L*AW-1:0]     src;
  logic [C-1:0]        ch_free;
  logic                any_load;
  logic                found;
  int                  ch_idx;
  int                  fill_start;

`ifdef MATCH_REQ_SCHED_RR_EN
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  // Group handshake and status. The sync pulse is the accept itself, so the
  // response sync loads the strobe in the same cycle the group is taken.
  assign req_group_ready = (state_q == IDLE);
  assign accept          = req_group_valid & req_group_ready;
  assign sync_fire       = accept;
  assign sync_strb       = req_group_strb;
  assign busy            = (state_q != IDLE);
  assign match_req_valid = ch_valid_q;

  // Flatten the per-channel registers onto the packed output buses.
  always_comb begin
    match_req_tag  = '0;
    match_req_addr = '0;
    for (int c = 0; c < C; c++) begin
      match_req_tag[c*TAG_BITS +: TAG_BITS] = ch_tag_q[c];
      match_req_addr[c*AW +: AW]            = ch_addr_q[c];
    end
  end

  // Next-state and channel refill. "avail" starts as the set of lanes still
  // to be issued: the incoming strobe on accept, or the pending mask while
  // issuing. Channels are visited in fill order. Each free channel grabs the
  // lowest remaining lane, and that lane is removed from avail so that it
  // can never be issued twice. Whatever is left in avail becomes the new
  // pending mask. A free channel that finds nothing drops its valid, and a
  // stalled channel keeps its tag and addr untouched.
  always_comb begin
    state_d     = state_q;
    ch_valid_d  = ch_valid_q;
    ch_tag_d    = ch_tag_q;
    ch_addr_d   = ch_addr_q;
    payload_d   = payload_q;
    resp_seen_d = resp_seen_q;
    avail       = '0;
    src         = payload_q;
    ch_free     = '0;
    any_load    = 1'b0;
    found       = 1'b0;
    ch_idx      = 0;
`ifdef MATCH_REQ_SCHED_RR_EN
    fill_start  = int'(rr_ptr_q);
    rr_ptr_d    = rr_ptr_q;
`else
    fill_start  = 0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          avail     = req_group_strb;
          src       = req_group_addr;
          payload_d = req_group_addr;
          ch_free   = '1;
          state_d   = (req_group_strb == '0) ? WAIT_RESP : ISSUE;
        end
      end
      ISSUE: begin
        avail   = pending_q;
        ch_free = ~ch_valid_q | match_req_ready;
        if (resp_group_fire) begin
          resp_seen_d = 1'b1;
        end
        if ((pending_q == '0) && (&ch_free)) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_group_fire || resp_seen_q) begin
          state_d     = IDLE;
          resp_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int k = 0; k < C; k++) begin
      ch_idx = fill_start + k;
      if (ch_idx >= C) begin
        ch_idx = ch_idx - C;
      end
      if (ch_free[ch_idx]) begin
        found              = 1'b0;
        ch_valid_d[ch_idx] = 1'b0;
        for (int lane = 0; lane < L; lane++) begin
          if (!found && avail[lane]) begin
            found              = 1'b1;
            any_load           = 1'b1;
            ch_valid_d[ch_idx] = 1'b1;
            ch_tag_d[ch_idx]   = TAG_BITS'(lane);
            ch_addr_d[ch_idx]  = src[lane*AW +: AW];
            avail[lane]        = 1'b0;
          end
        end
      end
    end

    pending_d = avail;

`ifdef MATCH_REQ_SCHED_RR_EN
    if (any_load) begin
      rr_ptr_d = (rr_ptr_q == CW'(C - 1)) ? '0 : rr_ptr_q + 1'b1;
    end
`endif
  end

  // State registers. Reset drops any group in flight; channel valids fall
  // on the first edge that sees rst_n low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_valid_q  <= '0;
      pending_q   <= '0;
      payload_q   <= '0;
      resp_seen_q <= 1'b0;
      for (int c = 0; c < C; c++) begin
        ch_tag_q[c]  <= '0;
        ch_addr_q[c] <= '0;
      end
`ifdef MATCH_REQ_SCHED_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ch_valid_q  <= ch_valid_d;
      pending_q   <= pending_d;
      payload_q   <= payload_d;
      resp_seen_q <= resp_seen_d;
      for (int c = 0; c < C; c++) begin
        ch_tag_q[c]  <= ch_tag_d[c];
        ch_addr_q[c] <= ch_addr_d[c];
      end
`ifdef MATCH_REQ_SCHED_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_match_req_sched.sv
// Testbench for match_req_sched with L=4 lanes, C=2 channels and AW=32.
// Every set lane that is offered is pushed to a scoreboard queue. A monitor
// pops the entry whenever a channel fires and checks its tag and payload.
// The scenario tasks check cycle-exact handshake, state and channel
// behaviour inline.

module tb_match_req_sched;

  localparam int L  = 4;
  localparam int C  = 2;
  localparam int TB = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_group_valid;
  logic            req_group_ready;
  logic [L-1:0]    req_group_strb;
  logic [L*AW-1:0] req_group_addr;
  logic [C-1:0]    match_req_valid;
  logic [C-1:0]    match_req_ready;
  logic [C*TB-1:0] match_req_tag;
  logic [C*AW-1:0] match_req_addr;
  logic            sync_fire;
  logic [L-1:0]    sync_strb;
  logic            resp_group_fire;
  logic            busy;

  typedef struct {
    logic [TB-1:0] tag;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [AW-1:0] lane_addr [L];
  logic [AW-1:0] held_addr;
  int          checks   = 0;
  int          failures = 0;
  int          mon_hit;

  match_req_sched #(.JOB_PE_IDX(0), .L(L), .C(C), .TAG_BITS(TB), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_group_valid (req_group_valid),
    .req_group_ready (req_group_ready),
    .req_group_strb  (req_group_strb),
    .req_group_addr  (req_group_addr),
    .match_req_valid (match_req_valid),
    .match_req_ready (match_req_ready),
    .match_req_tag   (match_req_tag),
    .match_req_addr  (match_req_addr),
    .sync_fire       (sync_fire),
    .sync_strb       (sync_strb),
    .resp_group_fire (resp_group_fire),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each channel fire must match an outstanding lane by
  // tag and carry that lane's payload, and it then retires the lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < C; c++) begin
        if (match_req_valid[c] && match_req_ready[c]) begin
          mon_hit = -1;
          for (int i = 0; i < sb_q.size(); i++) begin
            if (mon_hit < 0 && sb_q[i].tag == match_req_tag[c*TB +: TB]) mon_hit = i;
          end
          checks++;
          if (mon_hit < 0) begin
            failures++;
            $display("[TB] FAIL sb_tag ch%0d: got tag %0d, expected an outstanding lane (%0d left)",
                     c, match_req_tag[c*TB +: TB], sb_q.size());
          end else begin
            checks++;
            if (match_req_addr[c*AW +: AW] !== sb_q[mon_hit].addr) begin
              failures++;
              $display("[TB] FAIL sb_addr ch%0d tag %0d: got %h, expected %h",
                       c, sb_q[mon_hit].tag, match_req_addr[c*AW +: AW], sb_q[mon_hit].addr);
            end
            sb_q.delete(mon_hit);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Offers a group with random payloads and records every set lane.
  task automatic drive_group(input logic [L-1:0] strb);
    exp_t e;
    req_group_valid = 1'b1;
    req_group_strb  = strb;
    for (int i = 0; i < L; i++) begin
      lane_addr[i] = $urandom;
      req_group_addr[i*AW +: AW] = lane_addr[i];
      if (strb[i]) begin
        e.tag  = TB'(i);
        e.addr = lane_addr[i];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b, expected 1", req_group_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (sync_fire !== 1'b0) begin failures++; $display("[TB] FAIL reset_sync_fire: got %b, expected 0", sync_fire); end
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid: got %b, expected 00", match_req_valid); end
  endtask

  task automatic test_full_group();
    logic [TB-1:0] exp0, exp1;
    tick();
    match_req_ready = 2'b11;
    drive_group(4'b1111);
    sample();
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL full_sync_fire: got %b, expected 1", sync_fire); end
    checks++; if (sync_strb !== 4'b1111) begin failures++; $display("[TB] FAIL full_sync_strb: got %b, expected 1111", sync_strb); end
    tick();
    req_group_valid = 1'b0;
    sample();
    checks++; if (match_req_valid !== 2'b11) begin failures++; $display("[TB] FAIL full_t1_valid: got %b, expected 11", match_req_valid); end
    checks++; if (match_req_tag !== 4'b0100) begin failures++; $display("[TB] FAIL full_t1_tags: got %b, expected ch1=1 ch0=0", match_req_tag); end
    tick();
    sample();
`ifdef MATCH_REQ_SCHED_RR_EN
    exp0 = 2'd3; exp1 = 2'd2;
`else
    exp0 = 2'd2; exp1 = 2'd3;
`endif
    checks++; if (match_req_valid !== 2'b11) begin failures++; $display("[TB] FAIL full_t2_valid: got %b, expected 11", match_req_valid); end
    checks++; if (match_req_tag !== {exp1, exp0}) begin failures++; $display("[TB] FAIL full_t2_tags: got %b, expected %b", match_req_tag, {exp1, exp0}); end
    tick();
    sample();
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL full_t3_valid: got %b, expected 00", match_req_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL full_t3_busy: got %b, expected 1", busy); end
    checks++; if (req_group_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_t3_ready: got %b, expected 0", req_group_ready); end
    resp_group_fire = 1'b1;
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_idle_ready: got %b, expected 1", req_group_ready); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL full_drain: got %0d lanes left, expected 0", sb_q.size()); end
  endtask

  task automatic test_empty_group();
    tick();
    drive_group(4'b0000);
    sample();
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL empty_sync_fire: got %b, expected 1", sync_fire); end
    checks++; if (sync_strb !== 4'b0000) begin failures++; $display("[TB] FAIL empty_sync_strb: got %b, expected 0000", sync_strb); end
    tick();
    req_group_valid = 1'b0;
    sample();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL empty_wait_busy: got %b, expected 1", busy); end
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL empty_valid: got %b, expected 00", match_req_valid); end
    resp_group_fire = 1'b1;
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL empty_idle_ready: got %b, expected 1", req_group_ready); end
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL empty_idle_valid: got %b, expected 00", match_req_valid); end
  endtask

  task automatic test_stall();
    tick();
    match_req_ready = 2'b10;
    drive_group(4'b1010);
    sample();
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL stall_sync_fire: got %b, expected 1", sync_fire); end
    tick();
    req_group_valid = 1'b0;
    sample();
    checks++; if (match_req_valid !== 2'b11) begin failures++; $display("[TB] FAIL stall_t1_valid: got %b, expected 11", match_req_valid); end
    checks++; if (match_req_tag !== 4'b1101) begin failures++; $display("[TB] FAIL stall_t1_tags: got %b, expected ch1=3 ch0=1", match_req_tag); end
    held_addr = lane_addr[1];
    for (int cyc = 2; cyc <= 3; cyc++) begin
      tick();
      sample();
      checks++; if (match_req_valid !== 2'b01) begin failures++; $display("[TB] FAIL stall_t%0d_valid: got %b, expected 01", cyc, match_req_valid); end
      checks++; if (match_req_tag[0 +: TB] !== 2'd1) begin failures++; $display("[TB] FAIL stall_t%0d_tag: got %0d, expected 1", cyc, match_req_tag[0 +: TB]); end
      checks++; if (match_req_addr[0 +: AW] !== held_addr) begin failures++; $display("[TB] FAIL stall_t%0d_addr: got %h, expected %h", cyc, match_req_addr[0 +: AW], held_addr); end
    end
    tick();
    match_req_ready = 2'b11;
    sample();
    checks++; if (match_req_valid !== 2'b01) begin failures++; $display("[TB] FAIL stall_release_valid: got %b, expected 01", match_req_valid); end
    tick();
    sample();
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL stall_wait_valid: got %b, expected 00", match_req_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL stall_wait_busy: got %b, expected 1", busy); end
    resp_group_fire = 1'b1;
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_idle_ready: got %b, expected 1", req_group_ready); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL stall_drain: got %0d lanes left, expected 0", sb_q.size()); end
  endtask

  task automatic test_resp_early();
    tick();
    match_req_ready = 2'b11;
    drive_group(4'b0011);
    sample();
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL early_sync_fire: got %b, expected 1", sync_fire); end
    tick();
    req_group_valid = 1'b0;
    resp_group_fire = 1'b1;
    sample();
    checks++; if (match_req_valid !== 2'b11) begin failures++; $display("[TB] FAIL early_issue_valid: got %b, expected 11", match_req_valid); end
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL early_wait_busy: got %b, expected 1", busy); end
    checks++; if (req_group_ready !== 1'b0) begin failures++; $display("[TB] FAIL early_wait_ready: got %b, expected 0", req_group_ready); end
    tick();
    drive_group(4'b0001);
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_next_ready: got %b, expected 1", req_group_ready); end
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL early_next_sync_fire: got %b, expected 1", sync_fire); end
    tick();
    req_group_valid = 1'b0;
    sample();
    checks++; if (match_req_valid !== 2'b01) begin failures++; $display("[TB] FAIL early_next_valid: got %b, expected 01", match_req_valid); end
    tick();
    tick();
    sample();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL early_hold_busy: got %b, expected 1", busy); end
    resp_group_fire = 1'b1;
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL early_idle_ready: got %b, expected 1", req_group_ready); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL early_drain: got %0d lanes left, expected 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    tick();
    match_req_ready = 2'b00;
    drive_group(4'b0111);
    sample();
    checks++; if (sync_fire !== 1'b1) begin failures++; $display("[TB] FAIL rmid_sync_fire: got %b, expected 1", sync_fire); end
    tick();
    req_group_valid = 1'b0;
    rst_n = 1'b0;
    sample();
    checks++; if (match_req_valid !== 2'b11) begin failures++; $display("[TB] FAIL rmid_issue_valid: got %b, expected 11", match_req_valid); end
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    sample();
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL rmid_valid: got %b, expected 00", match_req_valid); end
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready: got %b, expected 1", req_group_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy: got %b, expected 0", busy); end
    checks++; if (sync_fire !== 1'b0) begin failures++; $display("[TB] FAIL rmid_sync_fire_after: got %b, expected 0", sync_fire); end
    tick();
    match_req_ready = 2'b11;
    drive_group(4'b0001);
    tick();
    req_group_valid = 1'b0;
    sample();
    checks++; if (match_req_valid !== 2'b01) begin failures++; $display("[TB] FAIL rmid_next_valid: got %b, expected 01", match_req_valid); end
    tick();
    sample();
    checks++; if (match_req_valid !== 2'b00) begin failures++; $display("[TB] FAIL rmid_next_done: got %b, expected 00", match_req_valid); end
    resp_group_fire = 1'b1;
    tick();
    resp_group_fire = 1'b0;
    sample();
    checks++; if (req_group_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_idle_ready: got %b, expected 1", req_group_ready); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL rmid_drain: got %0d lanes left, expected 0", sb_q.size()); end
  endtask

  initial begin
    rst_n           = 1'b0;
    req_group_valid = 1'b0;
    req_group_strb  = '0;
    req_group_addr  = '0;
    match_req_ready = 2'b11;
    resp_group_fire = 1'b0;
    test_reset();
    test_full_group();
    test_empty_group();
    test_stall();
    test_resp_early();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
